// File: rtl/pe_feeder_pkg.sv
// Shared types and default sizing for the PE row feeder.
package pe_feeder_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    LOAD,
    STREAM,
    DRAIN
  } feeder_state_t;

  typedef logic [DEF_W-1:0] operand_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {vld,data} for one lane of the skewed activation stream.
module skew_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         vld_i,
  output logic [W-1:0] data_o,
  output logic         vld_o
);

  logic [W:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= {vld_i, data_i};
      for (int unsigned k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign {vld_o, data_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_row_feeder.sv
// PE row feeder: loads stationary weights, streams diagonally skewed activations, drains the skew.
// Optional FEEDER_STALL_CNT_EN adds a saturating count of STREAM cycles without a_valid.
module pe_row_feeder
  import pe_feeder_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*W-1:0]   w_data,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [N*W-1:0]   a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  output logic [N*W-1:0]   pe_b,
  output logic [N-1:0]     pe_stat,
  output logic [N*W-1:0]   pe_a,
  output logic [N-1:0]     pe_a_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beats
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stalls
`endif
);

  localparam int DW = $clog2(N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(N - 2);

  feeder_state_t    state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             done_q, done_d;
  logic [N*W-1:0]   w_q;
  logic [CNT_W-1:0] beats_q;
  logic             job_start;
  logic             accept;

  assign job_start = (state_q == IDLE) && start;
  assign accept    = (state_q == STREAM) && a_valid;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = WAIT_W;
      WAIT_W:  if (w_valid) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM: begin
        if (a_valid && a_last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      // done is registered so it coincides with the last lane's final valid beat
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      w_q     <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      if ((state_q == WAIT_W) && w_valid) w_q <= w_data;
      if (job_start) beats_q <= '0;
      else if (accept && (beats_q != '1)) beats_q <= beats_q + 1'b1;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stalls_q <= '0;
    else if (job_start) stalls_q <= '0;
    else if ((state_q == STREAM) && !a_valid && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
  end

  assign stalls = stalls_q;
`endif

  assign w_ready = (state_q == WAIT_W);
  assign a_ready = (state_q == STREAM);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign beats   = beats_q;
  assign pe_b    = w_q;
  assign pe_stat = {N{state_q == LOAD}};

  // Lane i has depth i+1: the stage-0 register plus i cycles of skew.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .W    (W),
      .DEPTH(i + 1)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .data_i(accept ? a_data[i*W +: W] : '0),
      .vld_i (accept),
      .data_o(pe_a[i*W +: W]),
      .vld_o (pe_a_vld[i])
    );
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Self-checking bench for pe_row_feeder; per-lane scoreboard of skewed activations.
module tb_pe_row_feeder;
  import pe_feeder_pkg::*;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N*W-1:0]   w_data = '0;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [N*W-1:0]   a_data = '0;
  logic             a_valid = 1'b0;
  logic             a_last = 1'b0;
  logic             a_ready;
  logic [N*W-1:0]   pe_b;
  logic [N-1:0]     pe_stat;
  logic [N*W-1:0]   pe_a;
  logic [N-1:0]     pe_a_vld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] beats;
`ifdef FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stalls;
`endif

  pe_row_feeder #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .w_data  (w_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_last  (a_last),
    .a_ready (a_ready),
    .pe_b    (pe_b),
    .pe_stat (pe_stat),
    .pe_a    (pe_a),
    .pe_a_vld(pe_a_vld),
    .busy    (busy),
    .done    (done),
    .beats   (beats)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stalls  (stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int       due;
    logic     vld;
    operand_t data;
  } exp_t;

  exp_t lq [N][$];

  localparam logic [N*W-1:0] WEIGHTS = {8'h04, 8'h03, 8'h02, 8'h01};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each lane must show exactly the queued entries at their due cycles
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (lq[i].size() > 0 && lq[i][0].due == cyc) begin
          exp_t e;
          e = lq[i].pop_front();
          n_cmp++;
          if (pe_a_vld[i] !== e.vld || pe_a[i*W +: W] !== e.data) begin
            n_err++;
            $display("FAIL lane%0d_cyc%0d: got vld=%b data=%h, expected vld=%b data=%h",
                     i, cyc, pe_a_vld[i], pe_a[i*W +: W], e.vld, e.data);
          end
        end else if (pe_a_vld[i] !== 1'b0) begin
          n_cmp++;
          n_err++;
          $display("FAIL lane%0d_unexpected_vld cyc%0d: got vld=%b, expected 0", i, cyc, pe_a_vld[i]);
        end
      end
    end
  end

  function automatic logic [N*W-1:0] mkvec(input logic [W-1:0] base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(i * 32);
    return v;
  endfunction

  // Drives one STREAM slot at a negedge; pushes skewed expectations when the slot is accepted
  task automatic drive_vec(input logic v, input logic last, input logic [N*W-1:0] d);
    exp_t e;
    a_valid = v;
    a_last  = last;
    a_data  = d;
    if (a_ready === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        e.due  = cyc + 1 + i;
        e.vld  = v;
        e.data = v ? d[i*W +: W] : '0;
        lq[i].push_back(e);
      end
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_data  = '0;
  endtask

  task automatic start_job(input logic [N*W-1:0] w);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    w_valid = 1'b1;
    w_data  = w;
    @(negedge clk);
    w_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(output int steps, output bit seen);
    seen  = 1'b0;
    steps = 0;
    for (int k = 0; k < 32; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      steps++;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (busy !== 1'b0 || beats !== '0 || pe_b !== '0 || pe_a_vld !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: got busy=%b beats=%0d pe_b=%h vld=%b done=%b, expected all 0",
               busy, beats, pe_b, pe_a_vld, done);
    end
    start_job(WEIGHTS);
    drive_vec(1'b1, 1'b0, mkvec(8'h50));
    drive_vec(1'b1, 1'b0, mkvec(8'h51));
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) lq[i].delete();
    #1;
    n_cmp++;
    if (pe_a !== '0 || pe_a_vld !== '0 || pe_b !== '0 || pe_stat !== '0) begin
      n_err++;
      $display("FAIL reset_datapath: got pe_a=%h vld=%b pe_b=%h stat=%b, expected 0", pe_a, pe_a_vld, pe_b, pe_stat);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || beats !== '0 || a_ready !== 1'b0 || w_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b done=%b beats=%0d a_ready=%b w_ready=%b, expected 0",
               busy, done, beats, a_ready, w_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || w_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b w_ready=%b done=%b, expected 0", busy, w_ready, done);
    end
  endtask

  // Leaves the DUT in STREAM for test_skew
  task automatic test_weight_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || w_ready !== 1'b1 || pe_stat !== '0) begin
      n_err++;
      $display("FAIL wait_w: got busy=%b w_ready=%b stat=%b, expected 1 1 0", busy, w_ready, pe_stat);
    end
    w_valid = 1'b1;
    w_data  = WEIGHTS;
    @(negedge clk);
    w_valid = 1'b0;
    w_data  = '0;
    n_cmp++;
    if (pe_stat !== 4'hF || pe_b !== WEIGHTS || w_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load: got stat=%h pe_b=%h w_ready=%b, expected F %h 0", pe_stat, pe_b, w_ready, WEIGHTS);
    end
    @(negedge clk);
    n_cmp++;
    if (pe_stat !== 4'h0 || pe_b !== WEIGHTS || a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_after: got stat=%h pe_b=%h a_ready=%b, expected 0 %h 1", pe_stat, pe_b, a_ready, WEIGHTS);
    end
  endtask

  task automatic test_skew();
    int  steps;
    bit  seen;
    logic [N*W-1:0] last_v;
    last_v = mkvec(8'd12);
    drive_vec(1'b1, 1'b0, mkvec(8'd10));
    drive_vec(1'b1, 1'b0, mkvec(8'd11));
    drive_vec(1'b1, 1'b1, last_v);
    wait_done(steps, seen);
    n_cmp++;
    if (!seen || steps != N - 1) begin
      n_err++;
      $display("FAIL skew_done: got seen=%b steps=%0d, expected 1 %0d", seen, steps, N - 1);
    end
    n_cmp++;
    if (pe_a_vld[N-1] !== 1'b1 || pe_a[(N-1)*W +: W] !== last_v[(N-1)*W +: W]) begin
      n_err++;
      $display("FAIL skew_last_lane: got vld=%b data=%h, expected 1 %h",
               pe_a_vld[N-1], pe_a[(N-1)*W +: W], last_v[(N-1)*W +: W]);
    end
    n_cmp++;
    if (beats !== 16'd3) begin
      n_err++;
      $display("FAIL skew_beats: got %0d, expected 3", beats);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || pe_b !== WEIGHTS) begin
      n_err++;
      $display("FAIL skew_after: got done=%b busy=%b pe_b=%h, expected 0 0 %h", done, busy, pe_b, WEIGHTS);
    end
  endtask

  task automatic test_bubble();
    int steps;
    bit seen;
    start_job(WEIGHTS);
    drive_vec(1'b1, 1'b0, mkvec(8'h21));
    drive_vec(1'b0, 1'b0, mkvec(8'hEE));
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_state: got a_ready=%b, expected 1", a_ready);
    end
    drive_vec(1'b1, 1'b1, mkvec(8'h42));
    wait_done(steps, seen);
    n_cmp++;
    if (!seen || beats !== 16'd2) begin
      n_err++;
      $display("FAIL bubble_done: got seen=%b beats=%0d, expected 1 2", seen, beats);
    end
`ifdef FEEDER_STALL_CNT_EN
    n_cmp++;
    if (stalls !== 16'd1) begin
      n_err++;
      $display("FAIL bubble_stalls: got %0d, expected 1", stalls);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int steps;
    bit seen;
    start_job(mkvec(8'h07));
    drive_vec(1'b1, 1'b1, mkvec(8'h99));
    n_cmp++;
    if (a_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_drain: got a_ready=%b busy=%b, expected 0 1", a_ready, busy);
    end
    wait_done(steps, seen);
    n_cmp++;
    if (!seen || steps != N - 1 || beats !== 16'd1) begin
      n_err++;
      $display("FAIL single_done: got seen=%b steps=%0d beats=%0d, expected 1 %0d 1", seen, steps, beats, N - 1);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL single_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_ignored_start();
    int steps;
    bit seen;
    start_job(WEIGHTS);
    drive_vec(1'b1, 1'b0, mkvec(8'h30));
    drive_vec(1'b1, 1'b0, mkvec(8'h31));
    start = 1'b1;
    drive_vec(1'b1, 1'b0, mkvec(8'h32));
    start = 1'b0;
    n_cmp++;
    if (beats !== 16'd3 || a_ready !== 1'b1 || w_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ign_start: got beats=%0d a_ready=%b w_ready=%b, expected 3 1 0", beats, a_ready, w_ready);
    end
    drive_vec(1'b0, 1'b1, mkvec(8'h77));
    n_cmp++;
    if (a_ready !== 1'b1 || beats !== 16'd3) begin
      n_err++;
      $display("FAIL last_no_valid: got a_ready=%b beats=%0d, expected 1 3", a_ready, beats);
    end
    drive_vec(1'b1, 1'b1, mkvec(8'h33));
    wait_done(steps, seen);
    n_cmp++;
    if (!seen || beats !== 16'd4) begin
      n_err++;
      $display("FAIL ign_done: got seen=%b beats=%0d, expected 1 4", seen, beats);
    end
`ifdef FEEDER_STALL_CNT_EN
    n_cmp++;
    if (stalls !== 16'd1) begin
      n_err++;
      $display("FAIL ign_stalls: got %0d, expected 1", stalls);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: got %0d pending entries, expected 0",
               lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_weight_load();
    test_skew();
    test_bubble();
    test_single_beat();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
